// File: rtl/hazard_ctrl.sv
// Hazard/sequencing control for the 5-stage pipeline: forwarding selects, load-use and PC hazards, multiply hold, perf counters.
// Control outputs are combinational from the current inputs and state; only the multiply FSM and the event counters are registered.
module hazard_ctrl #(
  parameter int MUL_LAT = 3,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       RA1D,
  input  logic [3:0]       RA2D,
  input  logic [3:0]       RA1E,
  input  logic [3:0]       RA2E,
  input  logic [3:0]       WA3E,
  input  logic [3:0]       WA3M,
  input  logic [3:0]       WA3W,
  input  logic             RegWriteE,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic             MemtoRegE,
  input  logic             PCSrcD,
  input  logic             PCSrcE,
  input  logic             PCSrcM,
  input  logic             PCSrcW,
  input  logic             BranchTakenE,
  input  logic             MulStartE,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushM,
  output logic             Busy,
  output logic [CNT_W-1:0] StallCount,
  output logic [CNT_W-1:0] FlushCount
);

  localparam int            CW        = $clog2(MUL_LAT) + 1;
  localparam bit            MUL_MULTI = (MUL_LAT > 1);
  localparam logic [CW-1:0] CNT_LOAD  = MUL_MULTI ? CW'(MUL_LAT - 2) : '0;

  typedef enum logic {IDLE, MUL_BUSY} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic             ldr_stall;
  logic             pc_pend;

  // Memory stage wins over writeback: it holds the younger result.
  function automatic logic [1:0] fwd_sel(input logic [3:0] ra, input logic [3:0] wa_m,
                                         input logic rw_m, input logic [3:0] wa_w,
                                         input logic rw_w);
    if (rw_m && ra == wa_m)      return 2'b10;
    else if (rw_w && ra == wa_w) return 2'b01;
    else                         return 2'b00;
  endfunction

  assign ForwardAE = fwd_sel(RA1E, WA3M, RegWriteM, WA3W, RegWriteW);
  assign ForwardBE = fwd_sel(RA2E, WA3M, RegWriteM, WA3W, RegWriteW);

  assign ldr_stall = MemtoRegE && RegWriteE && (RA1D == WA3E || RA2D == WA3E);
  assign pc_pend   = PCSrcD | PCSrcE | PCSrcM;
  assign Busy      = (state_q == MUL_BUSY);

  always_comb begin
    StallF = ldr_stall | pc_pend;
    StallD = ldr_stall;
    StallE = 1'b0;
    FlushD = pc_pend | PCSrcW | BranchTakenE;
    FlushE = ldr_stall | BranchTakenE;
    FlushM = 1'b0;
    // A multiply freezes everything upstream and feeds bubbles into memory.
    if (Busy) begin
      StallF = 1'b1;
      StallD = 1'b1;
      StallE = 1'b1;
      FlushD = 1'b0;
      FlushE = 1'b0;
      FlushM = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (MulStartE && MUL_MULTI && !FlushE) begin
          state_d = MUL_BUSY;
          cnt_d   = CNT_LOAD;
        end
      end
      MUL_BUSY: begin
        if (cnt_q == '0) state_d = IDLE;
        else             cnt_d   = cnt_q - CW'(1);
      end
      default: state_d = IDLE;
    endcase

    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (StallD && stall_cnt_q != {CNT_W{1'b1}}) stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if (FlushE && flush_cnt_q != {CNT_W{1'b1}}) flush_cnt_d = flush_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign StallCount = stall_cnt_q;
  assign FlushCount = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: stimulus pushes predicted outputs, a negedge monitor pops and compares.
module tb_hazard_ctrl;

  localparam int MUL_LAT = 3;
  localparam int CNT_W   = 4;
  localparam int CMAX    = (1 << CNT_W) - 1;

  typedef struct {
    logic [3:0] ra1d, ra2d, ra1e, ra2e, wa3e, wa3m, wa3w;
    logic rwe, rwm, rww, m2re, pcd, pce, pcm, pcw, bte, mul;
  } stim_t;

  typedef struct {
    int fa, fb, sf, sd, se, fd, fe, fm, busy, scnt, fcnt;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [3:0] RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W;
  logic RegWriteE, RegWriteM, RegWriteW, MemtoRegE;
  logic PCSrcD, PCSrcE, PCSrcM, PCSrcW, BranchTakenE, MulStartE;
  logic [1:0] ForwardAE, ForwardBE;
  logic StallF, StallD, StallE, FlushD, FlushE, FlushM, Busy;
  logic [CNT_W-1:0] StallCount, FlushCount;

  logic [1:0] b1_fa, b1_fb;
  logic b1_sf, b1_sd, b1_se, b1_fd, b1_fe, b1_fm, b1_busy;
  logic [15:0] b1_scnt, b1_fcnt;

  int checks = 0;
  int failures = 0;
  exp_t exp_q[$];

  int m_busy_left = 0;
  int m_scnt = 0;
  int m_fcnt = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.MUL_LAT(MUL_LAT), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .RA1D(RA1D), .RA2D(RA2D), .RA1E(RA1E), .RA2E(RA2E),
    .WA3E(WA3E), .WA3M(WA3M), .WA3W(WA3W),
    .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .MemtoRegE(MemtoRegE), .PCSrcD(PCSrcD), .PCSrcE(PCSrcE), .PCSrcM(PCSrcM),
    .PCSrcW(PCSrcW), .BranchTakenE(BranchTakenE), .MulStartE(MulStartE),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .StallF(StallF), .StallD(StallD), .StallE(StallE),
    .FlushD(FlushD), .FlushE(FlushE), .FlushM(FlushM), .Busy(Busy),
    .StallCount(StallCount), .FlushCount(FlushCount)
  );

  hazard_ctrl #(.MUL_LAT(1), .CNT_W(16)) dut1 (
    .clk(clk), .reset(reset),
    .RA1D(RA1D), .RA2D(RA2D), .RA1E(RA1E), .RA2E(RA2E),
    .WA3E(WA3E), .WA3M(WA3M), .WA3W(WA3W),
    .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .MemtoRegE(MemtoRegE), .PCSrcD(PCSrcD), .PCSrcE(PCSrcE), .PCSrcM(PCSrcM),
    .PCSrcW(PCSrcW), .BranchTakenE(BranchTakenE), .MulStartE(MulStartE),
    .ForwardAE(b1_fa), .ForwardBE(b1_fb),
    .StallF(b1_sf), .StallD(b1_sd), .StallE(b1_se),
    .FlushD(b1_fd), .FlushE(b1_fe), .FlushM(b1_fm), .Busy(b1_busy),
    .StallCount(b1_scnt), .FlushCount(b1_fcnt)
  );

  task automatic chk(input string nm, input int act, input int expv);
    checks++;
    if (act != expv) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, expv, $time);
    end
  endtask

  function automatic stim_t zero_stim();
    stim_t s;
    s = '{default: '0};
    return s;
  endfunction

  // Reference behaviour: busy is a remaining-cycle count, counters are clamped integers.
  function automatic exp_t predict(input stim_t s);
    exp_t e;
    int ldr, pcp;
    e.fa = (s.rwm && s.ra1e == s.wa3m) ? 2 : (s.rww && s.ra1e == s.wa3w) ? 1 : 0;
    e.fb = (s.rwm && s.ra2e == s.wa3m) ? 2 : (s.rww && s.ra2e == s.wa3w) ? 1 : 0;
    ldr = (s.m2re && s.rwe && (s.ra1d == s.wa3e || s.ra2d == s.wa3e)) ? 1 : 0;
    pcp = (s.pcd || s.pce || s.pcm) ? 1 : 0;
    e.busy = (m_busy_left > 0) ? 1 : 0;
    if (e.busy == 1) begin
      e.sf = 1; e.sd = 1; e.se = 1; e.fd = 0; e.fe = 0; e.fm = 1;
    end else begin
      e.sf = (ldr | pcp);
      e.sd = ldr;
      e.se = 0;
      e.fd = (pcp | int'(s.pcw) | int'(s.bte));
      e.fe = (ldr | int'(s.bte));
      e.fm = 0;
    end
    e.scnt = m_scnt;
    e.fcnt = m_fcnt;
    return e;
  endfunction

  function automatic void model_edge(input stim_t s, input exp_t e);
    m_scnt = (m_scnt + e.sd > CMAX) ? CMAX : m_scnt + e.sd;
    m_fcnt = (m_fcnt + e.fe > CMAX) ? CMAX : m_fcnt + e.fe;
    if (m_busy_left > 0) m_busy_left--;
    else if (s.mul && MUL_LAT > 1 && e.fe == 0) m_busy_left = MUL_LAT - 1;
  endfunction

  task automatic apply(input stim_t s);
    RA1D = s.ra1d; RA2D = s.ra2d; RA1E = s.ra1e; RA2E = s.ra2e;
    WA3E = s.wa3e; WA3M = s.wa3m; WA3W = s.wa3w;
    RegWriteE = s.rwe; RegWriteM = s.rwm; RegWriteW = s.rww; MemtoRegE = s.m2re;
    PCSrcD = s.pcd; PCSrcE = s.pce; PCSrcM = s.pcm; PCSrcW = s.pcw;
    BranchTakenE = s.bte; MulStartE = s.mul;
  endtask

  // Called just after a rising edge; returns just after the next one.
  task automatic step(input stim_t s);
    exp_t e;
    apply(s);
    e = predict(s);
    exp_q.push_back(e);
    @(posedge clk);
    model_edge(s, e);
    #1;
  endtask

  function automatic stim_t rand_stim();
    stim_t s;
    s.ra1d = 4'($urandom_range(0, 3)); s.ra2d = 4'($urandom_range(0, 3));
    s.ra1e = 4'($urandom_range(0, 3)); s.ra2e = 4'($urandom_range(0, 3));
    s.wa3e = 4'($urandom_range(0, 3)); s.wa3m = 4'($urandom_range(0, 3));
    s.wa3w = 4'($urandom_range(0, 3));
    s.rwe = ($urandom_range(0, 1) == 1); s.rwm = ($urandom_range(0, 1) == 1);
    s.rww = ($urandom_range(0, 1) == 1); s.m2re = ($urandom_range(0, 9) < 3);
    s.pcd = ($urandom_range(0, 19) == 0); s.pce = ($urandom_range(0, 19) == 0);
    s.pcm = ($urandom_range(0, 19) == 0); s.pcw = ($urandom_range(0, 19) == 0);
    s.bte = ($urandom_range(0, 9) == 0); s.mul = ($urandom_range(0, 6) == 0);
    return s;
  endfunction

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("ForwardAE", int'(ForwardAE), e.fa);
        chk("ForwardBE", int'(ForwardBE), e.fb);
        chk("StallF", int'(StallF), e.sf);
        chk("StallD", int'(StallD), e.sd);
        chk("StallE", int'(StallE), e.se);
        chk("FlushD", int'(FlushD), e.fd);
        chk("FlushE", int'(FlushE), e.fe);
        chk("FlushM", int'(FlushM), e.fm);
        chk("Busy", int'(Busy), e.busy);
        chk("StallCount", int'(StallCount), e.scnt);
        chk("FlushCount", int'(FlushCount), e.fcnt);
        chk("lat1_Busy", int'(b1_busy), 0);
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    stim_t s;
    apply(zero_stim());
    #3;
    chk("rst_Busy", int'(Busy), 0);
    chk("rst_StallCount", int'(StallCount), 0);
    chk("rst_FlushCount", int'(FlushCount), 0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;

    s = zero_stim();
    s.ra1e = 3; s.wa3m = 3; s.rwm = 1; s.wa3w = 3; s.rww = 1; s.ra2e = 5;
    step(s);
    s.rwm = 0;
    step(s);

    s = zero_stim();
    s.m2re = 1; s.rwe = 1; s.wa3e = 2; s.ra2d = 2;
    step(s);
    step(zero_stim());

    s = zero_stim(); s.bte = 1;
    step(s);
    s = zero_stim(); s.pcd = 1;
    step(s);

    s = zero_stim(); s.mul = 1;
    step(s);
    repeat (3) step(zero_stim());

    s = zero_stim(); s.mul = 1;
    repeat (5) step(s);
    repeat (3) step(zero_stim());

    for (int i = 0; i < 1500; i++) step(rand_stim());
    repeat (3) step(zero_stim());

    // Asynchronous reset on the first busy cycle, between edges.
    s = zero_stim(); s.mul = 1;
    step(s);
    apply(zero_stim());
    #1;
    chk("pre_rst_Busy", int'(Busy), 1);
    reset = 1'b0;
    #1;
    chk("midmul_Busy", int'(Busy), 0);
    chk("midmul_StallF", int'(StallF), 0);
    chk("midmul_StallCount", int'(StallCount), 0);
    chk("midmul_FlushCount", int'(FlushCount), 0);
    #3;
    reset = 1'b1;
    m_busy_left = 0;
    m_scnt = 0;
    m_fcnt = 0;
    @(posedge clk);
    #1;
    repeat (2) step(zero_stim());

    s = zero_stim();
    s.m2re = 1; s.rwe = 1; s.wa3e = 7; s.ra1d = 7;
    repeat (20) step(s);
    step(zero_stim());

    @(negedge clk);
    #1;
    chk("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
